sobel_window: RTL and testbench

//   Downstream neighbour of the RGB-to-gray stage in the Sobel pipeline.

---
 rtl/sobel_window.sv | 128 ++++++++++++
 tb/tb_sobel_window.sv | 446 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sobel_window.sv
// 3x3 neighbourhood window generator for the Sobel pipeline: two line buffers plus a shifting window.
// Optional build macro SOBEL_WINDOW_SOF_EN adds sof_i to resync the raster counters to (0,0).
module sobel_window #(
    parameter int WIDTH_P   = 8,
    parameter int LINE_W_P  = 640,
    parameter int FRAME_H_P = 480
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 valid_i,
    output logic                 ready_o,
    input  logic [WIDTH_P-1:0]   gray_i,
    output logic                 valid_o,
    input  logic                 ready_i,
    output logic [9*WIDTH_P-1:0] win_o,
    output logic                 eof_o
`ifdef SOBEL_WINDOW_SOF_EN
    ,
    input  logic                 sof_i
`endif
);

    localparam int COL_W = $clog2(LINE_W_P);
    localparam int ROW_W = $clog2(FRAME_H_P);
    localparam logic [COL_W-1:0] COL_LAST = COL_W'(LINE_W_P - 1);
    localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(FRAME_H_P - 1);

    typedef logic [2:0][2:0][WIDTH_P-1:0] win_t;  // [row][col], row 0 = oldest line

    logic [WIDTH_P-1:0] lb0_q [LINE_W_P];  // line row-2
    logic [WIDTH_P-1:0] lb1_q [LINE_W_P];  // line row-1

    logic [COL_W-1:0] col_q, col_d, cur_col;
    logic [ROW_W-1:0] row_q, row_d, cur_row;
    win_t             win_q, win_d;
    win_t             out_win_q, out_win_d;
    logic             out_valid_q, out_valid_d;
    logic             out_eof_q, out_eof_d;
    logic             sof;
    logic             accept;
    logic [WIDTH_P-1:0] lb0_rd, lb1_rd;

`ifdef SOBEL_WINDOW_SOF_EN
    assign sof = sof_i;
`else
    assign sof = 1'b0;
`endif

    assign ready_o = ready_i || !out_valid_q;
    assign accept  = valid_i && ready_o;
    assign cur_col = sof ? '0 : col_q;
    assign cur_row = sof ? '0 : row_q;
    assign lb0_rd  = lb0_q[cur_col];
    assign lb1_rd  = lb1_q[cur_col];

    assign valid_o = out_valid_q;
    assign eof_o   = out_eof_q;
    assign win_o   = out_win_q;

    always_comb begin
        // NOTE: every signal gets a default first so no path leaves it unassigned (no latches).
        win_d       = win_q;
        col_d       = col_q;
        row_d       = row_q;
        out_win_d   = out_win_q;
        out_valid_d = out_valid_q;
        out_eof_d   = out_eof_q;

        if (accept) begin
            for (int r = 0; r < 3; r++) begin
                for (int c = 0; c < 2; c++) begin
                    win_d[r][c] = win_q[r][c+1];
                end
            end
            win_d[0][2] = lb0_rd;
            win_d[1][2] = lb1_rd;
            win_d[2][2] = gray_i;

            if (cur_col == COL_LAST) begin
                col_d = '0;
                row_d = (cur_row == ROW_LAST) ? '0 : cur_row + ROW_W'(1);
            end else begin
                col_d = cur_col + COL_W'(1);
                row_d = cur_row;
            end
        end

        // Columns 0/1 still hold the previous line's pixels, so only col>=2 windows are whole.
        if (accept && cur_row >= ROW_W'(2) && cur_col >= COL_W'(2)) begin
            out_valid_d = 1'b1;
            out_win_d   = win_d;
            out_eof_d   = (cur_row == ROW_LAST) && (cur_col == COL_LAST);
        end else if (ready_i) begin
            out_valid_d = 1'b0;
            out_eof_d   = 1'b0;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            col_q       <= '0;
            row_q       <= '0;
            out_valid_q <= 1'b0;
            out_eof_q   <= 1'b0;
            out_win_q   <= '0;
        end else begin
            col_q       <= col_d;
            row_q       <= row_d;
            out_valid_q <= out_valid_d;
            out_eof_q   <= out_eof_d;
            out_win_q   <= out_win_d;
        end
    end

    always_ff @(posedge clk_i) begin
        win_q <= win_d;
    end

    // NOTE: line buffers are not reset; their contents are only used once row>=2 rewrites them.
    always_ff @(posedge clk_i) begin
        if (accept) begin
            lb0_q[cur_col] <= lb1_rd;
            lb1_q[cur_col] <= gray_i;
        end
    end

endmodule

// File: tb/tb_sobel_window.sv
// Bench for sobel_window: a 4x4 instance for directed frames and an 8x6 instance for random handshakes.
// Expected windows come from a frame-image reference model pushed to per-instance scoreboards.
module tb_sobel_window;

    localparam int W = 8;

    typedef struct packed {
        logic [9*W-1:0] win;
        logic           eof;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;

    logic           valid_a = 1'b0, ready_i_a = 1'b1;
    logic [W-1:0]   gray_a = '0;
    logic           ready_o_a, valid_o_a, eof_a;
    logic [9*W-1:0] win_a;

    logic           valid_b = 1'b0, ready_i_b = 1'b1;
    logic [W-1:0]   gray_b = '0;
    logic           ready_o_b, valid_o_b, eof_b;
    logic [9*W-1:0] win_b;

`ifdef SOBEL_WINDOW_SOF_EN
    logic sof_a = 1'b0, sof_b = 1'b0;
`endif

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    // Reference model state: a whole frame image per instance
    int           m_row [2];
    int           m_col [2];
    logic [W-1:0] img [2][6][8];
    exp_t         q_a [$];
    exp_t         q_b [$];

    int             win_cnt_a = 0, win_cnt_b = 0, eof_cnt_b = 0;
    bit             capture_a = 0;
    logic [9*W-1:0] cap_win_a = '0;
    bit             seen_valid_a = 0;
    int             first_valid_cyc = 0;
    int             last_acc_cyc = 0;

    sobel_window #(.WIDTH_P(W), .LINE_W_P(4), .FRAME_H_P(4)) dut_a (
        .clk_i(clk), .rst_i(rst), .valid_i(valid_a), .ready_o(ready_o_a), .gray_i(gray_a),
        .valid_o(valid_o_a), .ready_i(ready_i_a), .win_o(win_a), .eof_o(eof_a)
`ifdef SOBEL_WINDOW_SOF_EN
        , .sof_i(sof_a)
`endif
    );

    sobel_window #(.WIDTH_P(W), .LINE_W_P(8), .FRAME_H_P(6)) dut_b (
        .clk_i(clk), .rst_i(rst), .valid_i(valid_b), .ready_o(ready_o_b), .gray_i(gray_b),
        .valid_o(valid_o_b), .ready_i(ready_i_b), .win_o(win_b), .eof_o(eof_b)
`ifdef SOBEL_WINDOW_SOF_EN
        , .sof_i(sof_b)
`endif
    );

    always #5 clk = ~clk;

    initial forever begin
        @(posedge clk);
        cyc = cyc + 1;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic [9*W-1:0] mk_win(input int p8, p7, p6, p5, p4, p3, p2, p1, p0);
        return {W'(p8), W'(p7), W'(p6), W'(p5), W'(p4), W'(p3), W'(p2), W'(p1), W'(p0)};
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            m_row[i] = 0;
            m_col[i] = 0;
        end
    endtask

    task automatic model_accept(input int id, input logic [W-1:0] p, input bit sof);
        exp_t e;
        int   lw, fh, r0, c0;
        lw = (id == 0) ? 4 : 8;
        fh = (id == 0) ? 4 : 6;
        if (sof) begin
            m_row[id] = 0;
            m_col[id] = 0;
        end
        r0 = m_row[id];
        c0 = m_col[id];
        img[id][r0][c0] = p;
        if (r0 >= 2 && c0 >= 2) begin
            e = '0;
            for (int r = 0; r < 3; r++)
                for (int c = 0; c < 3; c++)
                    e.win[(3*r+c)*W +: W] = img[id][r0-2+r][c0-2+c];
            e.eof = (r0 == fh - 1) && (c0 == lw - 1);
            if (id == 0) q_a.push_back(e);
            else         q_b.push_back(e);
        end
        if (c0 == lw - 1) begin
            m_col[id] = 0;
            m_row[id] = (r0 == fh - 1) ? 0 : r0 + 1;
        end else begin
            m_col[id] = c0 + 1;
        end
    endtask

    // Scoreboard monitors: compare on every output handshake
    initial forever begin
        exp_t e;
        @(negedge clk);
        if (valid_o_a && !seen_valid_a) begin
            seen_valid_a    = 1;
            first_valid_cyc = cyc;
        end
        if (valid_o_a && ready_i_a) begin
            n_checks++;
            if (q_a.size() == 0) begin
                n_fail++;
                $display("FAIL mon_a unexpected window: got %h eof %b, none expected", win_a, eof_a);
            end else begin
                e = q_a.pop_front();
                if (win_a !== e.win || eof_a !== e.eof) begin
                    n_fail++;
                    $display("FAIL mon_a window: got %h eof %b, expected %h eof %b", win_a, eof_a, e.win, e.eof);
                end
            end
            win_cnt_a++;
            if (capture_a) begin
                cap_win_a = win_a;
                capture_a = 0;
            end
        end
    end

    initial forever begin
        exp_t e;
        @(negedge clk);
        if (valid_o_b && ready_i_b) begin
            n_checks++;
            if (q_b.size() == 0) begin
                n_fail++;
                $display("FAIL mon_b unexpected window: got %h eof %b, none expected", win_b, eof_b);
            end else begin
                e = q_b.pop_front();
                if (win_b !== e.win || eof_b !== e.eof) begin
                    n_fail++;
                    $display("FAIL mon_b window: got %h eof %b, expected %h eof %b", win_b, eof_b, e.win, e.eof);
                end
            end
            win_cnt_b++;
            if (eof_b) eof_cnt_b++;
        end
    end

    task automatic send_a(input logic [W-1:0] p, input bit sof);
        bit done = 0;
        gray_a  = p;
        valid_a = 1'b1;
`ifdef SOBEL_WINDOW_SOF_EN
        sof_a = sof;
`endif
        for (int i = 0; i < 64 && !done; i++) begin
            @(negedge clk);
            if (ready_o_a) begin
                model_accept(0, p, sof);
                last_acc_cyc = cyc;
                done = 1;
            end
            @(posedge clk);
            #1;
        end
        valid_a = 1'b0;
`ifdef SOBEL_WINDOW_SOF_EN
        sof_a = 1'b0;
`endif
        n_checks++;
        if (!done) begin
            n_fail++;
            $display("FAIL send_a accept timeout: pixel %0d not accepted, required within 64 cycles", p);
        end
    endtask

    task automatic send_b(input logic [W-1:0] p);
        bit done = 0;
        gray_b  = p;
        valid_b = 1'b1;
        for (int i = 0; i < 200 && !done; i++) begin
            @(negedge clk);
            if (ready_o_b) begin
                model_accept(1, p, 1'b0);
                done = 1;
            end
            @(posedge clk);
            #1;
        end
        valid_b = 1'b0;
        n_checks++;
        if (!done) begin
            n_fail++;
            $display("FAIL send_b accept timeout: pixel %0d not accepted, required within 200 cycles", p);
        end
    endtask

    task automatic drain_a(input string name);
        bit done = 0;
        for (int i = 0; i < 200 && !done; i++) begin
            @(negedge clk);
            if (q_a.size() == 0 && !valid_o_a) done = 1;
        end
        @(posedge clk);
        #1;
        n_checks++;
        if (!done) begin
            n_fail++;
            $display("FAIL %s drain: %0d windows outstanding, required 0", name, q_a.size());
        end
    endtask

    task automatic check_first_frame(input string name);
        n_checks++;
        if (win_cnt_a !== 4) begin
            n_fail++;
            $display("FAIL %s window count: got %0d, required 4", name, win_cnt_a);
        end
        n_checks++;
        if (cap_win_a !== mk_win(10, 9, 8, 6, 5, 4, 2, 1, 0)) begin
            n_fail++;
            $display("FAIL %s first window: got %h, required %h", name, cap_win_a, mk_win(10, 9, 8, 6, 5, 4, 2, 1, 0));
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        n_checks++;
        if (valid_o_a !== 1'b0 || valid_o_b !== 1'b0) begin
            n_fail++;
            $display("FAIL reset valid_o: got a=%b b=%b, required 0", valid_o_a, valid_o_b);
        end
        n_checks++;
        if (eof_a !== 1'b0 || win_a !== '0) begin
            n_fail++;
            $display("FAIL reset outputs: got eof %b win %h, required 0", eof_a, win_a);
        end
        n_checks++;
        if (ready_o_a !== 1'b1) begin
            n_fail++;
            $display("FAIL reset ready_o: got %b, required 1", ready_o_a);
        end
        @(posedge clk);
        #1;
        rst = 1'b0;
        model_reset();
    endtask

    task automatic test_stream();
        int acc10 = 0;
        win_cnt_a    = 0;
        seen_valid_a = 0;
        capture_a    = 1;
        for (int i = 0; i < 16; i++) begin
            send_a(W'(i), 1'b0);
            if (i == 10) acc10 = last_acc_cyc;
        end
        drain_a("stream");
        check_first_frame("stream");
        n_checks++;
        if (first_valid_cyc !== acc10 + 1) begin
            n_fail++;
            $display("FAIL stream latency: first valid at cycle %0d, required %0d", first_valid_cyc, acc10 + 1);
        end
    endtask

    task automatic test_stall();
        win_cnt_a = 0;
        fork
            begin
                for (int i = 0; i < 16; i++) send_a(W'(i), 1'b0);
            end
            begin
                bit             got = 0;
                logic [9*W-1:0] held;
                for (int i = 0; i < 100 && !got; i++) begin
                    @(negedge clk);
                    if (valid_o_a) got = 1;
                end
                n_checks++;
                if (!got) begin
                    n_fail++;
                    $display("FAIL stall first window: valid_o never rose, required within 100 cycles");
                end
                @(posedge clk);
                #1;
                ready_i_a = 1'b0;
                @(negedge clk);
                held = win_a;
                for (int k = 0; k < 3; k++) begin
                    if (k > 0) @(negedge clk);
                    n_checks++;
                    if (valid_o_a !== 1'b1 || win_a !== held || ready_o_a !== 1'b0) begin
                        n_fail++;
                        $display("FAIL stall hold %0d: got valid %b ready_o %b win %h, required 1 0 %h",
                                 k, valid_o_a, ready_o_a, win_a, held);
                    end
                end
                @(posedge clk);
                #1;
                ready_i_a = 1'b1;
            end
        join
        drain_a("stall");
        n_checks++;
        if (win_cnt_a !== 4) begin
            n_fail++;
            $display("FAIL stall window count: got %0d, required 4", win_cnt_a);
        end
    endtask

    task automatic test_back_to_back();
        win_cnt_a = 0;
        for (int i = 0; i < 16; i++) send_a(W'(i), 1'b0);
        for (int i = 0; i < 16; i++) begin
            if (i == 2) capture_a = 1;
            send_a(W'(100 + i), 1'b0);
        end
        drain_a("b2b");
        n_checks++;
        if (win_cnt_a !== 8) begin
            n_fail++;
            $display("FAIL b2b window count: got %0d, required 8", win_cnt_a);
        end
        n_checks++;
        if (cap_win_a !== mk_win(110, 109, 108, 106, 105, 104, 102, 101, 100)) begin
            n_fail++;
            $display("FAIL b2b second frame first window: got %h, required %h",
                     cap_win_a, mk_win(110, 109, 108, 106, 105, 104, 102, 101, 100));
        end
    endtask

    task automatic test_mid_reset();
        for (int i = 0; i < 8; i++) send_a(W'(i), 1'b0);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        model_reset();
        @(negedge clk);
        n_checks++;
        if (valid_o_a !== 1'b0) begin
            n_fail++;
            $display("FAIL mid_reset valid_o: got %b, required 0", valid_o_a);
        end
        @(posedge clk);
        #1;
        win_cnt_a = 0;
        capture_a = 1;
        for (int i = 0; i < 16; i++) send_a(W'(i), 1'b0);
        drain_a("mid_reset");
        check_first_frame("mid_reset");
    endtask

`ifdef SOBEL_WINDOW_SOF_EN
    task automatic test_sof();
        for (int i = 0; i < 6; i++) send_a(W'(i), 1'b0);
        win_cnt_a = 0;
        capture_a = 1;
        for (int i = 0; i < 16; i++) send_a(W'(i), i == 0);
        drain_a("sof");
        check_first_frame("sof");
    endtask
`endif

    task automatic test_random();
        bit stop = 0;
        win_cnt_b = 0;
        eof_cnt_b = 0;
        fork
            begin
                for (int i = 0; i < 48; i++) begin
                    repeat ($urandom_range(0, 2)) begin
                        @(posedge clk);
                        #1;
                    end
                    send_b(W'($urandom_range(0, 255)));
                end
                stop = 1;
            end
            begin
                while (!stop) begin
                    @(posedge clk);
                    #1;
                    ready_i_b = ($urandom_range(0, 3) != 0);
                end
                ready_i_b = 1'b1;
            end
        join
        begin
            bit done = 0;
            for (int i = 0; i < 200 && !done; i++) begin
                @(negedge clk);
                if (q_b.size() == 0 && !valid_o_b) done = 1;
            end
            n_checks++;
            if (!done) begin
                n_fail++;
                $display("FAIL random drain: %0d windows outstanding, required 0", q_b.size());
            end
        end
        n_checks++;
        if (win_cnt_b !== 24) begin
            n_fail++;
            $display("FAIL random window count: got %0d, required 24", win_cnt_b);
        end
        n_checks++;
        if (eof_cnt_b !== 1) begin
            n_fail++;
            $display("FAIL random eof count: got %0d, required 1", eof_cnt_b);
        end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_stream();
        test_stall();
        test_back_to_back();
        test_mid_reset();
`ifdef SOBEL_WINDOW_SOF_EN
        test_sof();
`endif
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
